// File: rtl/uart_tx_fifo.sv
// UART transmitter with a FIFO_DEPTH-entry transmit FIFO and a configurable frame format.
// Define UART_TX_BREAK_EN to add the send_break input and the line-break states.
module uart_tx_fifo #(
    parameter int unsigned CLOCK_RATE = 24000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          valid,
    input  logic [DATA_BITS-1:0]          in,
    output logic                          ready,
    output logic                          out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef UART_TX_BREAK_EN
    ,
    input  logic                          send_break
`endif
);

    localparam int unsigned DIVISOR = CLOCK_RATE / BAUD_RATE;
    localparam int unsigned CNT_W   = $clog2(DIVISOR + 1);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned BIT_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK,
        S_BRK_GAP
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 out_q, out_d;
    logic                 busy_q, busy_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] head_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 can_pop_c;
    logic                 tick_c;

`ifdef UART_TX_BREAK_EN
    localparam int unsigned BRK_LEN = (DATA_BITS + 2 + ((PARITY != 0) ? 1 : 0)) * DIVISOR;
    localparam int unsigned BRK_W   = $clog2(BRK_LEN + 1);
    logic [BRK_W-1:0] brk_q, brk_d;
`endif

    assign ready     = (level_q != LVL_W'(FIFO_DEPTH));
    assign out       = out_q;
    assign busy      = busy_q;
    assign level     = level_q;
    assign push_c    = valid && ready;
    assign head_c    = mem_q[rd_ptr_q];
    assign can_pop_c = enable && (level_q != '0);
    assign tick_c    = (baud_q == CNT_W'(DIVISOR - 1));

    // Frame sequencer; a pop always loads the head word and enters START.
    always_comb begin
        state_d = state_q;
        baud_d  = tick_c ? '0 : baud_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        out_d   = out_q;
        pop_c   = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_d   = brk_q;
`endif
        case (state_q)
            S_IDLE: begin
                out_d  = 1'b1;
                baud_d = '0;
                bit_d  = '0;
`ifdef UART_TX_BREAK_EN
                if (send_break) begin
                    state_d = S_BREAK;
                    out_d   = 1'b0;
                    brk_d   = '0;
                end else
`endif
                if (can_pop_c) begin
                    pop_c = 1'b1;
                end
            end
            S_START: begin
                if (tick_c) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    out_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            S_DATA: begin
                if (tick_c) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            out_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            out_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        out_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (tick_c) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    out_d   = 1'b1;
                end
            end
            S_STOP: begin
                if (tick_c) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        if (can_pop_c) begin
                            pop_c = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            out_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BREAK: begin
                out_d  = 1'b0;
                baud_d = '0;
                if (brk_q != BRK_W'(BRK_LEN - 1)) begin
                    brk_d = brk_q + BRK_W'(1);
                end else if (!send_break) begin
                    state_d = S_BRK_GAP;
                    out_d   = 1'b1;
                end
            end
            S_BRK_GAP: begin
                out_d = 1'b1;
                if (tick_c) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                out_d   = 1'b1;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
        if (pop_c) begin
            state_d = S_START;
            out_d   = 1'b0;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = head_c;
            par_d   = (PARITY == 1) ? ~(^head_c) : ^head_c;
        end
    end

    // FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            out_q    <= 1'b1;
            busy_q   <= 1'b0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef UART_TX_BREAK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brk_q <= '0;
        end else begin
            brk_q <= brk_d;
        end
    end
`endif

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= in;
        end
    end

endmodule
